load_distributor: RTL and testbench

LOAD_DISTRIBUTOR -- requirements
Module: load_distributor

---
 rtl/load_distributor_pkg.sv | 31 +++
 rtl/load_distributor_rr_arbiter.sv | 31 +++
 rtl/load_distributor.sv | 163 ++++++++++++++++
 tb/tb_load_distributor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/load_distributor_pkg.sv
// Shared types and constants for the load distributor: FSM encoding,
// bus widths, pixel counter width and the default frame size.
package load_distributor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    localparam int VGA_X_W           = 10;
    localparam int VGA_Y_W           = 9;
    localparam int COORD_W           = 36;
    localparam int PIX_CNT_W         = 19;
    localparam int PIX_PER_FRAME_DEF = 307200;

    // Solver count never exceeds 8, so a 3-bit pointer covers every legal build.
    localparam int MAX_SOLVERS = 8;
    localparam int PTR_W       = 3;

    // Encode a one-hot solver mask into its index.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_SOLVERS-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SOLVERS; i++) begin
            if (oh[i]) idx = idx | PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/load_distributor_rr_arbiter.sv
// Round-robin selector: picks the first eligible solver at or after rr_ptr,
// wrapping modulo NUM_SOLVERS.
module rr_arbiter
    import load_distributor_pkg::*;
#(
    parameter int NUM_SOLVERS = 4
) (
    input  logic [NUM_SOLVERS-1:0] eligible,
    input  logic [PTR_W-1:0]       rr_ptr,
    output logic [NUM_SOLVERS-1:0] grant,
    output logic                   grant_valid
);

    int idx;

    // Scan from the pointer and grant the first eligible solver found.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SOLVERS;
            if (!grant_valid && eligible[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_distributor.sv
// Load distributor: accepts one pixel at a time from the coordinate
// generator and hands it to an idle Mandelbrot solver in round-robin order.
module load_distributor
    import load_distributor_pkg::*;
#(
    parameter int NUM_SOLVERS   = 4,
    parameter int PIX_PER_FRAME = PIX_PER_FRAME_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iCoordValid,
    output logic                   oCoordReady,
    input  logic [VGA_X_W-1:0]     iVGAX,
    input  logic [VGA_Y_W-1:0]     iVGAY,
    input  logic [COORD_W-1:0]     iCoordX,
    input  logic [COORD_W-1:0]     iCoordY,
    output logic [VGA_X_W-1:0]     oSolverVGAX,
    output logic [VGA_Y_W-1:0]     oSolverVGAY,
    output logic [COORD_W-1:0]     oSolverX,
    output logic [COORD_W-1:0]     oSolverY,
    output logic [NUM_SOLVERS-1:0] oSolverStart,
    input  logic [NUM_SOLVERS-1:0] iSolverBusy,
    output logic [PIX_CNT_W-1:0]   oPixelCount,
    output logic                   oFrameDone
);

    state_e                 state_q, state_d;
    logic [VGA_X_W-1:0]     hold_vx_q, hold_vx_d;
    logic [VGA_Y_W-1:0]     hold_vy_q, hold_vy_d;
    logic [COORD_W-1:0]     hold_x_q, hold_x_d;
    logic [COORD_W-1:0]     hold_y_q, hold_y_d;
    logic [VGA_X_W-1:0]     bus_vx_q, bus_vx_d;
    logic [VGA_Y_W-1:0]     bus_vy_q, bus_vy_d;
    logic [COORD_W-1:0]     bus_x_q, bus_x_d;
    logic [COORD_W-1:0]     bus_y_q, bus_y_d;
    logic [NUM_SOLVERS-1:0] start_q, start_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    // Two-stage reservation: a solver stays reserved for two cycles after
    // issue, covering the delay before its busy flag rises.
    logic [NUM_SOLVERS-1:0] res_a_q, res_a_d;
    logic [NUM_SOLVERS-1:0] res_b_q, res_b_d;
    logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                   frame_done_q, frame_done_d;

    logic [NUM_SOLVERS-1:0] eligible;
    logic [NUM_SOLVERS-1:0] grant;
    logic                   grant_valid;
    logic [PTR_W-1:0]       sel_idx;

    assign eligible = ~iSolverBusy & ~(res_a_q | res_b_q);
    assign sel_idx  = onehot_to_idx(MAX_SOLVERS'(start_q));

    rr_arbiter #(
        .NUM_SOLVERS (NUM_SOLVERS)
    ) u_rr_arbiter (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Next-state logic for the handshake / hold / issue sequence.
    always_comb begin
        state_d      = state_q;
        hold_vx_d    = hold_vx_q;
        hold_vy_d    = hold_vy_q;
        hold_x_d     = hold_x_q;
        hold_y_d     = hold_y_q;
        bus_vx_d     = bus_vx_q;
        bus_vy_d     = bus_vy_q;
        bus_x_d      = bus_x_q;
        bus_y_d      = bus_y_q;
        start_d      = '0;
        rr_ptr_d     = rr_ptr_q;
        res_a_d      = '0;
        res_b_d      = res_a_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iCoordValid) begin
                    hold_vx_d = iVGAX;
                    hold_vy_d = iVGAY;
                    hold_x_d  = iCoordX;
                    hold_y_d  = iCoordY;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                // Start pulse, bus data and pixel count all appear together in S_ISSUE.
                if (grant_valid) begin
                    start_d  = grant;
                    bus_vx_d = hold_vx_q;
                    bus_vy_d = hold_vy_q;
                    bus_x_d  = hold_x_q;
                    bus_y_d  = hold_y_q;
                    if (pix_cnt_q == PIX_CNT_W'(PIX_PER_FRAME - 1)) begin
                        pix_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rr_ptr_d = (sel_idx == PTR_W'(NUM_SOLVERS - 1)) ? '0 : sel_idx + 1'b1;
                res_a_d  = start_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q      <= S_IDLE;
            hold_vx_q    <= '0;
            hold_vy_q    <= '0;
            hold_x_q     <= '0;
            hold_y_q     <= '0;
            bus_vx_q     <= '0;
            bus_vy_q     <= '0;
            bus_x_q      <= '0;
            bus_y_q      <= '0;
            start_q      <= '0;
            rr_ptr_q     <= '0;
            res_a_q      <= '0;
            res_b_q      <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_vx_q    <= hold_vx_d;
            hold_vy_q    <= hold_vy_d;
            hold_x_q     <= hold_x_d;
            hold_y_q     <= hold_y_d;
            bus_vx_q     <= bus_vx_d;
            bus_vy_q     <= bus_vy_d;
            bus_x_q      <= bus_x_d;
            bus_y_q      <= bus_y_d;
            start_q      <= start_d;
            rr_ptr_q     <= rr_ptr_d;
            res_a_q      <= res_a_d;
            res_b_q      <= res_b_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign oCoordReady  = (state_q == S_IDLE) && !reset;
    assign oSolverVGAX  = bus_vx_q;
    assign oSolverVGAY  = bus_vy_q;
    assign oSolverX     = bus_x_q;
    assign oSolverY     = bus_y_q;
    assign oSolverStart = start_q;
    assign oPixelCount  = pix_cnt_q;
    assign oFrameDone   = frame_done_q;

endmodule

// File: tb/tb_load_distributor.sv
// Directed testbench for load_distributor (4 solvers, 640x480 frame).
module tb_load_distributor;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        iCoordValid;
    logic        oCoordReady;
    logic [9:0]  iVGAX;
    logic [8:0]  iVGAY;
    logic [35:0] iCoordX;
    logic [35:0] iCoordY;
    logic [9:0]  oSolverVGAX;
    logic [8:0]  oSolverVGAY;
    logic [35:0] oSolverX;
    logic [35:0] oSolverY;
    logic [N-1:0] oSolverStart;
    logic [N-1:0] iSolverBusy;
    logic [18:0] oPixelCount;
    logic        oFrameDone;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    load_distributor #(.NUM_SOLVERS(N), .PIX_PER_FRAME(307200)) dut (
        .clk          (clk),
        .reset        (reset),
        .iCoordValid  (iCoordValid),
        .oCoordReady  (oCoordReady),
        .iVGAX        (iVGAX),
        .iVGAY        (iVGAY),
        .iCoordX      (iCoordX),
        .iCoordY      (iCoordY),
        .oSolverVGAX  (oSolverVGAX),
        .oSolverVGAY  (oSolverVGAY),
        .oSolverX     (oSolverX),
        .oSolverY     (oSolverY),
        .oSolverStart (oSolverStart),
        .iSolverBusy  (iSolverBusy),
        .oPixelCount  (oPixelCount),
        .oFrameDone   (oFrameDone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %0s: got %0h expected %0h", tag, got, exp);
    endtask

    // Hold reset for two edges, then release; checks reset-state outputs.
    task automatic do_reset();
        reset = 1'b1;
        iCoordValid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", oCoordReady, 0);
        check("rst_start", oSolverStart, 0);
        check("rst_count", oPixelCount, 0);
        check("rst_fdone", oFrameDone, 0);
        check("rst_bus_x", oSolverX, 0);
        check("rst_bus_vx", oSolverVGAX, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", oCoordReady, 1);
    endtask

    // Hand one pixel over and wait (bounded) for its start pulse.
    // lat counts clock edges from the handshake edge's cycle to the pulse.
    task automatic issue(input logic [9:0] vx, input logic [8:0] vy,
                         input logic [35:0] x, input logic [35:0] y,
                         output logic [N-1:0] st, output int lat, output int at_cyc);
        int n;
        n = 0;
        while (!oCoordReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_hs", oCoordReady, 1);
        iCoordValid = 1'b1;
        iVGAX = vx; iVGAY = vy; iCoordX = x; iCoordY = y;
        @(negedge clk);
        iCoordValid = 1'b0;
        lat = 1;
        while (oSolverStart == '0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        st = oSolverStart;
        at_cyc = cyc;
    endtask

    initial begin
        logic [N-1:0] st;
        int lat, c, prev;
        logic saw_start, saw_ready, bus_moved;
        logic [35:0] snap_x;
        logic [9:0]  snap_vx;

        reset = 1'b1; iCoordValid = 1'b0; iSolverBusy = '0;
        iVGAX = '0; iVGAY = '0; iCoordX = '0; iCoordY = '0;
        do_reset();

        // Single pixel, all solvers idle.
        issue(10'd5, 9'd7, 36'h1_0000_0000, 36'h0_8000_0000, st, lat, c);
        check("single_start", st, 4'b0001);
        check("single_latency", lat, 2);
        check("single_bus_vx", oSolverVGAX, 5);
        check("single_bus_vy", oSolverVGAY, 7);
        check("single_bus_x", oSolverX, 36'h1_0000_0000);
        check("single_bus_y", oSolverY, 36'h0_8000_0000);
        check("single_count", oPixelCount, 1);
        check("single_fdone", oFrameDone, 0);
        @(negedge clk);
        check("start_one_cycle", oSolverStart, 0);
        check("bus_holds_x", oSolverX, 36'h1_0000_0000);
        check("ready_after_issue", oCoordReady, 1);

        // Eight back-to-back pixels, round-robin rotation, one per 3 cycles.
        do_reset();
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            issue(10'(i + 20), 9'(i + 1), 36'(i) << 8, 36'(i + 3), st, lat, c);
            check($sformatf("b2b_start_%0d", i), st, 4'b0001 << (i % 4));
            check($sformatf("b2b_bus_x_%0d", i), oSolverX, 36'(i) << 8);
            check($sformatf("b2b_count_%0d", i), oPixelCount, i + 1);
            if (i > 0) check($sformatf("b2b_spacing_%0d", i), c - prev, 3);
            prev = c;
        end

        // All solvers busy: pixel is held, input ignored, no start.
        iSolverBusy = 4'b1111;
        @(negedge clk);
        iCoordValid = 1'b1;
        iVGAX = 10'd100; iVGAY = 9'd200; iCoordX = 36'hA_BCDE_F012; iCoordY = 36'h5_5555_5555;
        @(negedge clk);
        iVGAX = 10'd999; iCoordX = 36'hF_FFFF_FFFF;
        snap_x = oSolverX; snap_vx = oSolverVGAX;
        saw_start = 1'b0; saw_ready = 1'b0; bus_moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            saw_start = saw_start | (oSolverStart != '0);
            saw_ready = saw_ready | oCoordReady;
            bus_moved = bus_moved | (oSolverX != snap_x) | (oSolverVGAX != snap_vx);
            @(negedge clk);
        end
        iCoordValid = 1'b0;
        check("busy_no_start", saw_start, 0);
        check("busy_not_ready", saw_ready, 0);
        check("busy_bus_stable", bus_moved, 0);
        iSolverBusy = 4'b1011;
        @(negedge clk);
        check("busy_release_start", oSolverStart, 4'b0100);
        check("busy_release_vx", oSolverVGAX, 100);
        check("busy_release_vy", oSolverVGAY, 200);
        check("busy_release_x", oSolverX, 36'hA_BCDE_F012);
        check("busy_release_count", oPixelCount, 9);
        iSolverBusy = '0;
        @(negedge clk);
        check("busy_no_dup", oSolverStart, 0);

        // Frame wrap: preload the counter to the last pixel of the frame.
        dut.pix_cnt_q = 19'd307199;
        @(negedge clk);
        check("preload_count", oPixelCount, 307199);
        issue(10'd639, 9'd479, 36'h2, 36'h3, st, lat, c);
        check("wrap_start", st, 4'b1000);
        check("wrap_count", oPixelCount, 0);
        check("wrap_fdone", oFrameDone, 1);
        @(negedge clk);
        check("wrap_fdone_pulse", oFrameDone, 0);

        // Reset while a pixel is held.
        issue(10'd1, 9'd2, 36'h4, 36'h5, st, lat, c);
        check("pre_rst_start", st, 4'b0001);
        @(negedge clk);
        iCoordValid = 1'b1;
        iVGAX = 10'd55; iVGAY = 9'd66; iCoordX = 36'h77; iCoordY = 36'h88;
        @(negedge clk);
        iCoordValid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_hold_no_start", oSolverStart, 0);
        check("rst_hold_ready", oCoordReady, 0);
        @(negedge clk);
        check("rst_hold_no_start2", oSolverStart, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_no_start", oSolverStart, 0);
        check("post_rst_ready", oCoordReady, 1);
        check("post_rst_count", oPixelCount, 0);
        issue(10'd9, 9'd8, 36'h6, 36'h7, st, lat, c);
        check("post_rst_start", st, 4'b0001);
        check("post_rst_latency", lat, 2);
        check("post_rst_bus_x", oSolverX, 36'h6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
